// File: rtl/regbank_wb_arbiter.sv
// Round-robin writeback arbiter for the register bank's single write port.
// Optional stats counters: define REGBANK_WB_ARB_STATS_EN.
module regbank_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         rd,
  output logic [DATA_W-1:0]         rd_value,
  output logic                      busy
`ifdef REGBANK_WB_ARB_STATS_EN
  ,
  output logic [15:0]               conflict_cnt,
  output logic [7:0]                drop_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  logic [ADDR_W-1:0] rd_arr   [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     gidx;
  logic [IW-1:0]     ti;
  logic              gnt;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  int                t;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rd_arr[g]   = req_rd[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Pick the first valid requester after last_grant, wrapping around
  always_comb begin
    req_ready = '0;
    gnt       = 1'b0;
    gidx      = last_grant;
    sel_rd    = '0;
    sel_data  = '0;
    t         = 0;
    ti        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      t = int'(last_grant) + k;
      if (t >= NUM_REQ) t = t - NUM_REQ;
      ti = IW'(t);
      if (!gnt && !rst && req_valid[ti]) begin
        gnt           = 1'b1;
        gidx          = ti;
        req_ready[ti] = 1'b1;
        sel_rd        = rd_arr[ti];
        sel_data      = data_arr[ti];
      end
    end
  end

  assign busy = |(req_valid & ~req_ready);

  // Register the granted write; x0 targets are accepted but never written
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write  <= 1'b0;
      rd         <= '0;
      rd_value   <= '0;
      last_grant <= LAST;
    end else if (gnt) begin
      reg_write  <= (sel_rd != '0);
      rd         <= sel_rd;
      rd_value   <= sel_data;
      last_grant <= gidx;
    end else begin
      reg_write  <= 1'b0;
    end
  end

`ifdef REGBANK_WB_ARB_STATS_EN
  // Saturating counters for contention cycles and dropped x0 writes
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (busy && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
      if (gnt && sel_rd == '0 && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Self-checking bench: NUM_REQ=2 and NUM_REQ=4 instances vs a
// round-robin reference model, plus directed literal expectations.
module tb_regbank_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      a_v;
  logic [2*AW-1:0] a_rdi;
  logic [2*DW-1:0] a_di;
  logic [1:0]      a_rdy;
  logic            a_we;
  logic [AW-1:0]   a_rd;
  logic [DW-1:0]   a_val;
  logic            a_busy;

  logic [3:0]      b_v;
  logic [4*AW-1:0] b_rdi;
  logic [4*DW-1:0] b_di;
  logic [3:0]      b_rdy;
  logic            b_we;
  logic [AW-1:0]   b_rd;
  logic [DW-1:0]   b_val;
  logic            b_busy;

`ifdef REGBANK_WB_ARB_STATS_EN
  logic [15:0] a_cc, b_cc;
  logic [7:0]  a_dc, b_dc;
`endif

  regbank_wb_arbiter #(.NUM_REQ(2), .DATA_W(DW), .ADDR_W(AW)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_v), .req_rd(a_rdi), .req_data(a_di),
    .req_ready(a_rdy), .reg_write(a_we), .rd(a_rd),
    .rd_value(a_val), .busy(a_busy)
`ifdef REGBANK_WB_ARB_STATS_EN
    , .conflict_cnt(a_cc), .drop_cnt(a_dc)
`endif
  );

  regbank_wb_arbiter #(.NUM_REQ(4), .DATA_W(DW), .ADDR_W(AW)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_v), .req_rd(b_rdi), .req_data(b_di),
    .req_ready(b_rdy), .reg_write(b_we), .rd(b_rd),
    .rd_value(b_val), .busy(b_busy)
`ifdef REGBANK_WB_ARB_STATS_EN
    , .conflict_cnt(b_cc), .drop_cnt(b_dc)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state, one slot per instance (0: N=2, 1: N=4)
  int            m_lg  [2];
  logic          m_we  [2];
  logic [AW-1:0] m_rd  [2];
  logic [DW-1:0] m_val [2];
  int            m_cc  [2];
  int            m_dc  [2];

  function automatic int n_of(int s);
    return (s == 0) ? 2 : 4;
  endfunction

  function automatic logic [7:0] valid_of(int s);
    return (s == 0) ? 8'(a_v) : 8'(b_v);
  endfunction

  function automatic logic [AW-1:0] rd_of(int s, int i);
    return (s == 0) ? a_rdi[i*AW +: AW] : b_rdi[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] data_of(int s, int i);
    return (s == 0) ? a_di[i*DW +: DW] : b_di[i*DW +: DW];
  endfunction

  function automatic int pick(int s);
    logic [7:0] v;
    int i;
    v = valid_of(s);
    for (int k = 1; k <= n_of(s); k++) begin
      i = (m_lg[s] + k) % n_of(s);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_ready(int s);
    int g;
    g = pick(s);
    if (rst || g < 0) return 8'd0;
    return 8'd1 << g;
  endfunction

  initial begin
    for (int s = 0; s < 2; s++) begin
      m_lg[s] = 0; m_we[s] = 0; m_rd[s] = '0;
      m_val[s] = '0; m_cc[s] = 0; m_dc[s] = 0;
    end
  end

  // Model advance on every rising edge
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        m_lg[s] <= n_of(s) - 1;
        m_we[s] <= 1'b0;
        m_rd[s] <= '0;
        m_val[s] <= '0;
        m_cc[s] <= 0;
        m_dc[s] <= 0;
      end else begin
        if ((valid_of(s) & ~exp_ready(s)) != 8'd0 && m_cc[s] < 16'hFFFF)
          m_cc[s] <= m_cc[s] + 1;
        if (pick(s) >= 0) begin
          m_we[s]  <= rd_of(s, pick(s)) != '0;
          m_rd[s]  <= rd_of(s, pick(s));
          m_val[s] <= data_of(s, pick(s));
          m_lg[s]  <= pick(s);
          if (rd_of(s, pick(s)) == '0 && m_dc[s] < 255)
            m_dc[s] <= m_dc[s] + 1;
        end else begin
          m_we[s] <= 1'b0;
        end
      end
    end
  end

  // Compare DUT against model mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_ready", 64'(a_rdy), 64'(exp_ready(0)));
      chk("a_busy", 64'(a_busy),
          64'(|(valid_of(0) & ~exp_ready(0))));
      chk("a_we", 64'(a_we), 64'(m_we[0]));
      chk("a_rd", 64'(a_rd), 64'(m_rd[0]));
      chk("a_val", 64'(a_val), 64'(m_val[0]));
      chk("b_ready", 64'(b_rdy), 64'(exp_ready(1)));
      chk("b_busy", 64'(b_busy),
          64'(|(valid_of(1) & ~exp_ready(1))));
      chk("b_we", 64'(b_we), 64'(m_we[1]));
      chk("b_rd", 64'(b_rd), 64'(m_rd[1]));
      chk("b_val", 64'(b_val), 64'(m_val[1]));
`ifdef REGBANK_WB_ARB_STATS_EN
      chk("a_cc", 64'(a_cc), 64'(m_cc[0]));
      chk("a_dc", 64'(a_dc), 64'(m_dc[0]));
      chk("b_cc", 64'(b_cc), 64'(m_cc[1]));
      chk("b_dc", 64'(b_dc), 64'(m_dc[1]));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] a_acc;
  logic [3:0] b_acc;

  initial begin
    a_v = '0; a_rdi = '0; a_di = '0;
    b_v = '0; b_rdi = '0; b_di = '0;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // idle after reset
    repeat (5) step();
    @(negedge clk);
    chk("idle ready", 64'(a_rdy), 64'd0);
    chk("idle we", 64'(a_we), 64'd0);
    chk("idle rd", 64'(a_rd), 64'd0);
    chk("idle val", 64'(a_val), 64'd0);

    // requester 1 alone
    step();
    a_v = 2'b10;
    a_rdi[AW +: AW] = 5'd5;
    a_di[DW +: DW] = 32'hDEADBEEF;
    @(negedge clk);
    chk("r1 ready", 64'(a_rdy), 64'h2);
    step();
    a_v = 2'b00;
    @(negedge clk);
    chk("r1 we", 64'(a_we), 64'd1);
    chk("r1 rd", 64'(a_rd), 64'd5);
    chk("r1 val", 64'(a_val), 64'hDEADBEEF);
    step();
    @(negedge clk);
    chk("r1 we off", 64'(a_we), 64'd0);

    // both held valid: 0,1,0,1
    step();
    a_v = 2'b11;
    a_rdi = {5'd4, 5'd3};
    a_di = {32'hBBBB0002, 32'hAAAA0001};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr grant", 64'(a_rdy), (k % 2 == 1) ? 64'h2 : 64'h1);
      chk("rr busy", 64'(a_busy), 64'd1);
      if (k > 0)
        chk("rr bank rd", 64'(a_rd), (k % 2 == 1) ? 64'd3 : 64'd4);
      step();
    end

    // x0 drop
    a_v = 2'b01;
    a_rdi[0 +: AW] = 5'd0;
    a_di[0 +: DW] = 32'h1234;
    @(negedge clk);
    chk("drop ready", 64'(a_rdy), 64'h1);
    step();
    a_v = 2'b00;
    @(negedge clk);
    chk("drop we", 64'(a_we), 64'd0);
    chk("drop val", 64'(a_val), 64'h1234);
`ifdef REGBANK_WB_ARB_STATS_EN
    chk("drop cnt", 64'(a_dc), 64'd1);
`endif

    // reset while a req1 write is in flight
    step();
    a_v = 2'b10;
    a_rdi = {5'd7, 5'd9};
    a_di = {32'h77, 32'h99};
    @(negedge clk);
    chk("pre-rst ready", 64'(a_rdy), 64'h2);
    step();
    rst = 1'b1;
    a_v = 2'b11;
    a_rdi = {5'd10, 5'd9};
    @(negedge clk);
    chk("rst mask", 64'(a_rdy), 64'h0);
    chk("rst we pending", 64'(a_we), 64'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst we", 64'(a_we), 64'd0);
    chk("post-rst grant", 64'(a_rdy), 64'h1);
    step();
    a_v = 2'b00;

    // N=4 wrap-around between 0 and 3
    b_v = 4'b1001;
    b_rdi[0 +: AW] = 5'd1;
    b_rdi[3*AW +: AW] = 5'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wrap grant", 64'(b_rdy), (k % 2 == 1) ? 64'h8 : 64'h1);
      chk("wrap busy", 64'(b_busy), 64'd1);
      step();
    end
    b_v = 4'b0000;

`ifdef REGBANK_WB_ARB_STATS_EN
    // drop counter saturation
    a_v = 2'b01;
    a_rdi[0 +: AW] = 5'd0;
    repeat (270) step();
    a_v = 2'b00;
    @(negedge clk);
    chk("drop sat", 64'(a_dc), 64'hFF);
    step();
`endif

    // constrained random traffic obeying the hold-until-ready rule
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_acc = a_v & a_rdy;
      b_acc = b_v & b_rdy;
      step();
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!a_v[i] || a_acc[i]) begin
          a_v[i] = ($urandom_range(0, 2) != 0);
          a_rdi[i*AW +: AW] = AW'($urandom_range(0, 7));
          a_di[i*DW +: DW] = $urandom;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!b_v[i] || b_acc[i]) begin
          b_v[i] = ($urandom_range(0, 2) != 0);
          b_rdi[i*AW +: AW] = AW'($urandom_range(0, 7));
          b_di[i*DW +: DW] = $urandom;
        end
      end
    end

    rst = 1'b0;
    a_v = '0;
    b_v = '0;
    step();
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
